// File: rtl/draw_pkg.sv
// Shared definitions for the sprite drawing path: sequencer state encoding,
// default plot widths, sprite colours and a small sizing helper.
package draw_pkg;

    localparam int X_W_DEF   = 9;
    localparam int Y_W_DEF   = 8;
    localparam int COL_W_DEF = 3;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SELECT = 3'd1;
    localparam logic [2:0] ST_START  = 3'd2;
    localparam logic [2:0] ST_WAIT   = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_SELECT = ST_SELECT,
        S_START  = ST_START,
        S_WAIT   = ST_WAIT,
        S_DONE   = ST_DONE
    } state_t;

    localparam logic [2:0] BLACK = 3'b000;
    localparam logic [2:0] WHITE = 3'b111;

    // Width of an index into n items; never collapses to zero bits.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sprite_draw_sequencer_if.sv
// Bundle between the sprite engines / VGA plotter and the draw sequencer.
// master = sequencer side, slave = engines, plotter and frame timing.
interface sprite_draw_sequencer_if #(
    parameter int NUM_CH = 4,
    parameter int X_W    = 9,
    parameter int Y_W    = 8,
    parameter int COL_W  = 3
);
    logic                    frame_tick;
    logic [NUM_CH-1:0]       ch_req;
    logic [NUM_CH*X_W-1:0]   ch_x;
    logic [NUM_CH*Y_W-1:0]   ch_y;
    logic [NUM_CH*COL_W-1:0] ch_colour;
    logic [NUM_CH-1:0]       ch_valid;
    logic [NUM_CH-1:0]       ch_fin;
    logic [NUM_CH-1:0]       ch_go;
    logic [X_W-1:0]          plot_x;
    logic [Y_W-1:0]          plot_y;
    logic [COL_W-1:0]        plot_colour;
    logic                    plot;
    logic                    busy;
    logic                    frame_done;
    logic                    overrun;
    logic [NUM_CH-1:0]       timeout_err;

    modport master (
        input  frame_tick, ch_req, ch_x, ch_y, ch_colour, ch_valid, ch_fin,
        output ch_go, plot_x, plot_y, plot_colour, plot, busy, frame_done,
               overrun, timeout_err
    );

    modport slave (
        output frame_tick, ch_req, ch_x, ch_y, ch_colour, ch_valid, ch_fin,
        input  ch_go, plot_x, plot_y, plot_colour, plot, busy, frame_done,
               overrun, timeout_err
    );
endinterface

// File: rtl/prio_pick.sv
// Fixed-priority picker: lowest set bit of a mask wins. Purely combinational
// so it can be shared by other arbiters (e.g. collision handling).
module prio_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  mask,
    output logic [IW-1:0] idx,
    output logic          any
);
    // Scan from the top down so the lowest set index is the last assignment.
    always_comb begin
        idx = '0;
        any = |mask;
        for (int i = N - 1; i >= 0; i--) begin
            if (mask[i]) idx = IW'(i);
        end
    end
endmodule

// File: rtl/sprite_draw_sequencer.sv
// Per-frame draw arbiter: on an accepted frame tick every requesting sprite
// channel gets, in priority order, a start pulse and exclusive use of the
// plot port until it finishes or its watchdog expires.
module sprite_draw_sequencer #(
    parameter int NUM_CH  = 4,
    parameter int X_W     = 9,
    parameter int Y_W     = 8,
    parameter int COL_W   = 3,
    parameter int TIMEOUT = 4096,
    parameter int TO_W    = 13
) (
    input  logic                    clk,
    input  logic                    reset,
    sprite_draw_sequencer_if.master bus
);
    import draw_pkg::*;

    localparam int GW = idx_w(NUM_CH);

    state_t              state_q, state_d;
    logic [NUM_CH-1:0]   pending;
    logic [GW-1:0]       grant, pick_idx;
    logic                pick_any;
    logic [TO_W-1:0]     wd_cnt;
    logic [NUM_CH-1:0]   terr;
    logic [NUM_CH-1:0]   go;
    logic                done_pulse;
    logic [X_W-1:0]      sel_x, plot_x_q;
    logic [Y_W-1:0]      sel_y, plot_y_q;
    logic [COL_W-1:0]    sel_col, plot_col_q;
    logic                sel_valid, sel_fin, plot_q, overrun_q;
    logic                fin_ok, wd_hit;

    prio_pick #(.N(NUM_CH), .IW(GW)) u_pick (
        .mask (pending),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    // Route the granted channel's pixel stream and finish flag.
    always_comb begin
        sel_x     = '0;
        sel_y     = '0;
        sel_col   = '0;
        sel_valid = 1'b0;
        sel_fin   = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant == GW'(i)) begin
                sel_x     = bus.ch_x[i*X_W +: X_W];
                sel_y     = bus.ch_y[i*Y_W +: Y_W];
                sel_col   = bus.ch_colour[i*COL_W +: COL_W];
                sel_valid = bus.ch_valid[i];
                sel_fin   = bus.ch_fin[i];
            end
        end
    end

    // A finish level left over from an earlier grant must not end this one,
    // so fin only counts from the second WAIT cycle (counter non-zero).
    assign fin_ok = sel_fin && (wd_cnt != '0);
    assign wd_hit = (wd_cnt == TO_W'(TIMEOUT - 1));

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state decode plus the state-derived pulses (go, frame_done).
    always_comb begin
        state_d    = state_q;
        go         = '0;
        done_pulse = 1'b0;
        case (state_q)
            S_IDLE:   if (bus.frame_tick) state_d = S_SELECT;
            S_SELECT: state_d = pick_any ? S_START : S_DONE;
            S_START: begin
                for (int i = 0; i < NUM_CH; i++) go[i] = (grant == GW'(i));
                state_d = S_WAIT;
            end
            S_WAIT:   if (fin_ok || wd_hit) state_d = S_SELECT;
            S_DONE: begin
                done_pulse = 1'b1;
                state_d    = S_IDLE;
            end
            default:  state_d = S_IDLE;
        endcase
    end

    // Request snapshot, grant latch and per-channel retirement.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= '0;
            grant   <= '0;
        end else begin
            if (state_q == S_IDLE && bus.frame_tick) pending <= bus.ch_req;
            if (state_q == S_SELECT) grant <= pick_idx;
            if (state_q == S_WAIT && (fin_ok || wd_hit)) pending[grant] <= 1'b0;
        end
    end

    // Watchdog: cleared on start, counts WAIT cycles; sticky error per channel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_cnt <= '0;
            terr   <= '0;
        end else begin
            if (state_q == S_START) wd_cnt <= '0;
            else if (state_q == S_WAIT) wd_cnt <= wd_cnt + 1'b1;
            if (state_q == S_WAIT && !fin_ok && wd_hit) terr[grant] <= 1'b1;
        end
    end

    // Registered plot port; coordinates hold outside WAIT, write enable drops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            plot_q     <= 1'b0;
            plot_x_q   <= '0;
            plot_y_q   <= '0;
            plot_col_q <= '0;
        end else begin
            plot_q <= (state_q == S_WAIT) && sel_valid;
            if (state_q == S_WAIT) begin
                plot_x_q   <= sel_x;
                plot_y_q   <= sel_y;
                plot_col_q <= sel_col;
            end
        end
    end

    // A tick that arrives while a pass is running is dropped and flagged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) overrun_q <= 1'b0;
        else       overrun_q <= bus.frame_tick && (state_q != S_IDLE);
    end

    assign bus.ch_go       = go;
    assign bus.frame_done  = done_pulse;
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.plot        = plot_q;
    assign bus.plot_x      = plot_x_q;
    assign bus.plot_y      = plot_y_q;
    assign bus.plot_colour = plot_col_q;
    assign bus.overrun     = overrun_q;
    assign bus.timeout_err = terr;

endmodule

// File: tb/tb_sprite_draw_sequencer.sv
// Bench for sprite_draw_sequencer: behavioural sprite engines replay random
// pixel scripts; a pass-level model predicts grant order, plotted pixels with
// their cycle, busy/frame_done timing, overruns and watchdog flags.
module tb_sprite_draw_sequencer;
    localparam int NUM_CH  = 4;
    localparam int X_W     = 9;
    localparam int Y_W     = 8;
    localparam int COL_W   = 3;
    localparam int TIMEOUT = 16;
    localparam int TO_W    = 5;
    localparam int MAXL    = 24;

    logic CLOCK_50 = 1'b0;
    logic reset;
    always #5 CLOCK_50 = ~CLOCK_50;

    sprite_draw_sequencer_if #(.NUM_CH(NUM_CH), .X_W(X_W), .Y_W(Y_W), .COL_W(COL_W)) bus ();

    sprite_draw_sequencer #(
        .NUM_CH(NUM_CH), .X_W(X_W), .Y_W(Y_W), .COL_W(COL_W),
        .TIMEOUT(TIMEOUT), .TO_W(TO_W)
    ) dut (
        .clk   (CLOCK_50),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct { int t; logic [X_W-1:0] x; logic [Y_W-1:0] y; logic [COL_W-1:0] c; } pix_t;
    typedef struct { int t; int ch; } go_t;

    pix_t exp_plot[$];
    go_t  exp_go[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic [NUM_CH-1:0] exp_terr = '0;

    // Engine scripts: one step per cycle after the engine sees its go.
    logic             s_v [NUM_CH][MAXL];
    logic [X_W-1:0]   s_x [NUM_CH][MAXL];
    logic [Y_W-1:0]   s_y [NUM_CH][MAXL];
    logic [COL_W-1:0] s_c [NUM_CH][MAXL];
    int               s_len [NUM_CH];
    bit               s_fin [NUM_CH];
    int               eng_pos [NUM_CH];
    bit               armed [NUM_CH];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLOCK_50);
        #1;
        cyc++;
    endtask

    task automatic gen_scripts(input int fixed_len, input logic [NUM_CH-1:0] nofin);
        for (int i = 0; i < NUM_CH; i++) begin
            s_fin[i] = !nofin[i];
            if (nofin[i])          s_len[i] = MAXL;
            else if (fixed_len > 0) s_len[i] = fixed_len;
            else                   s_len[i] = int'($urandom_range(2, TIMEOUT));
            for (int j = 0; j < MAXL; j++) begin
                s_v[i][j] = (fixed_len > 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
                s_x[i][j] = X_W'($urandom_range(0, 319));
                s_y[i][j] = Y_W'($urandom_range(0, 239));
                s_c[i][j] = COL_W'($urandom_range(0, 7));
            end
        end
    endtask

    // Sprite engines: start one cycle after go, replay script, fin on last
    // step; idle engines emit decoy pixels at x=100 with random valid/fin.
    task automatic eng_tick();
        logic [NUM_CH-1:0]       v, f;
        logic [NUM_CH*X_W-1:0]   xs;
        logic [NUM_CH*Y_W-1:0]   ys;
        logic [NUM_CH*COL_W-1:0] cs;
        for (int i = 0; i < NUM_CH; i++) begin
            if (armed[i]) begin
                eng_pos[i] = 0;
                armed[i]   = 1'b0;
            end else if (eng_pos[i] >= 0) begin
                eng_pos[i]++;
                if (eng_pos[i] >= s_len[i]) eng_pos[i] = -1;
            end
            if (bus.ch_go[i]) armed[i] = 1'b1;
            if (eng_pos[i] >= 0) begin
                v[i]              = s_v[i][eng_pos[i]];
                xs[i*X_W +: X_W]  = s_x[i][eng_pos[i]];
                ys[i*Y_W +: Y_W]  = s_y[i][eng_pos[i]];
                cs[i*COL_W +: COL_W] = s_c[i][eng_pos[i]];
                f[i]              = s_fin[i] && (eng_pos[i] == s_len[i] - 1);
            end else begin
                v[i]              = 1'($urandom_range(0, 1));
                xs[i*X_W +: X_W]  = 9'd100;
                ys[i*Y_W +: Y_W]  = Y_W'($urandom_range(0, 239));
                cs[i*COL_W +: COL_W] = COL_W'($urandom_range(0, 7));
                f[i]              = 1'($urandom_range(0, 1));
            end
        end
        bus.ch_valid  = v;
        bus.ch_fin    = f;
        bus.ch_x      = xs;
        bus.ch_y      = ys;
        bus.ch_colour = cs;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            step();
            chk("idle_quiet", 64'({bus.plot, bus.busy, bus.ch_go, bus.frame_done}), 64'(0));
            eng_tick();
            bus.frame_tick = 1'b0;
            bus.ch_req     = NUM_CH'($urandom_range(0, 15));
        end
    endtask

    // One frame pass. ovr_off>0 injects an extra tick at t0+ovr_off;
    // tick_at_done injects it in the DONE cycle instead.
    task automatic run_frame(input logic [NUM_CH-1:0] req, input logic [NUM_CH-1:0] nofin,
                             input int fixed_len, input int ovr_off, input bit tick_at_done);
        int   t0, cur, w, done_t, ovr_t;
        pix_t p;
        go_t  g;
        gen_scripts(fixed_len, nofin);
        exp_plot.delete();
        exp_go.delete();
        t0  = cyc;
        cur = t0 + 1;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (req[ch]) begin
                exp_go.push_back('{cur + 1, ch});
                w = nofin[ch] ? TIMEOUT : s_len[ch];
                for (int j = 0; j < w; j++)
                    if (s_v[ch][j]) exp_plot.push_back('{cur + 3 + j, s_x[ch][j], s_y[ch][j], s_c[ch][j]});
                if (nofin[ch]) exp_terr[ch] = 1'b1;
                cur = cur + 2 + w;
            end
        end
        done_t = cur + 1;
        ovr_t  = tick_at_done ? done_t : ((ovr_off > 0) ? t0 + ovr_off : -10);

        bus.frame_tick = 1'b1;
        bus.ch_req     = req;
        eng_tick();
        while (cyc < done_t + 3) begin
            step();
            if (bus.plot) begin
                if (exp_plot.size() == 0) chk("plot_extra", 64'(1), 64'(0));
                else begin
                    p = exp_plot.pop_front();
                    chk("plot_pix", 64'({16'(cyc), bus.plot_x, bus.plot_y, bus.plot_colour}),
                        64'({16'(p.t), p.x, p.y, p.c}));
                end
            end
            if (bus.ch_go != '0) begin
                if (exp_go.size() == 0) chk("go_extra", 64'(bus.ch_go), 64'(0));
                else begin
                    g = exp_go.pop_front();
                    chk("ch_go", 64'({16'(cyc), bus.ch_go}), 64'({16'(g.t), NUM_CH'(1 << g.ch)}));
                end
            end
            chk("busy", 64'(bus.busy), 64'(cyc >= t0 + 1 && cyc <= done_t));
            chk("frame_done", 64'(bus.frame_done), 64'(cyc == done_t));
            chk("overrun", 64'(bus.overrun), 64'(cyc == ovr_t + 1));
            eng_tick();
            bus.frame_tick = (cyc == ovr_t);
            bus.ch_req     = NUM_CH'($urandom_range(0, 15));
        end
        bus.frame_tick = 1'b0;
        chk("plots_missing", 64'(exp_plot.size()), 64'(0));
        chk("gos_missing", 64'(exp_go.size()), 64'(0));
        chk("timeout_err", 64'(bus.timeout_err), 64'(exp_terr));
    endtask

    initial begin
        reset          = 1'b1;
        bus.frame_tick = 1'b0;
        bus.ch_req     = '0;
        bus.ch_valid   = '0;
        bus.ch_fin     = '0;
        bus.ch_x       = '0;
        bus.ch_y       = '0;
        bus.ch_colour  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            eng_pos[i] = -1;
            armed[i]   = 1'b0;
            s_len[i]   = 1;
            s_fin[i]   = 1'b1;
        end
        gen_scripts(0, '0);
        repeat (3) begin
            step();
            chk("reset_state", 64'({bus.ch_go, bus.plot, bus.busy, bus.frame_done, bus.overrun,
                                    bus.timeout_err, bus.plot_x, bus.plot_y, bus.plot_colour}), 64'(0));
        end
        reset = 1'b0;
        idle(3);

        run_frame(4'b1011, 4'b0000, 5, 0, 1'b0);   // three channels, 5 pixels each
        idle(30);
        run_frame(4'b0000, 4'b0000, 0, 0, 1'b0);   // empty pass
        idle(5);
        run_frame(4'b1111, 4'b0100, 0, 0, 1'b0);   // channel 2 never finishes
        idle(30);
        run_frame(4'b0110, 4'b0000, 0, 4, 1'b0);   // extra tick during channel 1 WAIT
        idle(30);
        run_frame(4'b0010, 4'b0000, 0, 0, 1'b1);   // extra tick in the DONE cycle
        idle(30);
        for (int k = 0; k < 6; k++) begin
            run_frame(NUM_CH'($urandom_range(0, 15)),
                      ($urandom_range(0, 2) == 0) ? NUM_CH'(1 << $urandom_range(0, 3)) : '0,
                      0, 0, 1'b0);
            idle(30);
        end

        // Reset in the middle of a WAIT.
        gen_scripts(10, '0);
        bus.frame_tick = 1'b1;
        bus.ch_req     = 4'b0110;
        eng_tick();
        repeat (5) begin
            step();
            eng_tick();
            bus.frame_tick = 1'b0;
        end
        chk("busy_before_reset", 64'(bus.busy), 64'(1));
        reset = 1'b1;
        #1;
        chk("async_reset", 64'({bus.ch_go, bus.plot, bus.busy, bus.timeout_err,
                                bus.frame_done, bus.overrun}), 64'(0));
        step();
        step();
        reset = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            eng_pos[i] = -1;
            armed[i]   = 1'b0;
        end
        exp_terr = '0;
        idle(3);
        run_frame(4'b0110, 4'b0000, 0, 0, 1'b0);
        idle(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
